// File: rtl/dcache_axi_line_bridge.sv
// dcache_axi_line_bridge
// Memory-side responder for D$ line requests. A refill becomes one AXI4 INCR
// read burst (AR/R) and a dirty-line writeback becomes one INCR write burst
// (AW/W/B). One transaction is outstanding at a time; the refilled line or
// the write completion is returned on the resp handshake.
//
// Ports
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   req_*                       D$ request: valid/ready, we, line address, line data
//   resp_*                      D$ response: valid/ready, line data (0 for writes), error
//   m_axi_ar*/m_axi_r*          AXI read address and read data channels
//   m_axi_aw*/m_axi_w*/m_axi_b* AXI write address, write data and write response channels
module dcache_axi_line_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LINE_BYTES     = 64,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_we_i,
    input  logic [ADDR_WIDTH-1:0]       req_addr_i,
    input  logic [LINE_BYTES*8-1:0]     req_data_i,

    output logic                        resp_valid_o,
    input  logic                        resp_ready_i,
    output logic [LINE_BYTES*8-1:0]     resp_data_o,
    output logic                        resp_err_o,

    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic [3:0]                  m_axi_arid,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,

    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,

    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [ADDR_WIDTH-1:0]       m_axi_awaddr,
    output logic [3:0]                  m_axi_awid,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,

    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,

    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    input  logic [1:0]                  m_axi_bresp
);

    localparam int unsigned LINE_W   = LINE_BYTES * 8;
    localparam int unsigned BEATS    = LINE_W / AXI_DATA_WIDTH;
    localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int unsigned WORD_SH  = $clog2(AXI_DATA_WIDTH);
    localparam int unsigned LIDX_W   = $clog2(LINE_W);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RESP
    } state_e;

    state_e                  state_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_W-1:0]       line_q;

    logic [ADDR_WIDTH-1:0]   aligned_addr_c;
    logic [BEAT_W-1:0]       beat_next_c;
    logic [LIDX_W-1:0]       rd_lsb_c;
    logic [LIDX_W-1:0]       wr_lsb_c;
    logic [LINE_W-1:0]       rd_line_c;

    // Constant burst attributes; address comes from the captured request.
    assign m_axi_araddr  = addr_q;
    assign m_axi_arid    = 4'(AXI_ID);
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = 3'($clog2(STRB_W));
    assign m_axi_arburst = 2'b01;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awid    = 4'(AXI_ID);
    assign m_axi_awlen   = 8'(BEATS - 1);
    assign m_axi_awsize  = 3'($clog2(STRB_W));
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = '1;

    // Masking (rather than slicing) keeps every address bit in use.
    assign aligned_addr_c = req_addr_i & ~ADDR_WIDTH'(LINE_BYTES - 1);

    assign beat_next_c = beat_q + BEAT_W'(1);
    assign rd_lsb_c    = LIDX_W'({beat_q, WORD_SH'(0)});
    assign wr_lsb_c    = LIDX_W'({beat_next_c, WORD_SH'(0)});

    // Line buffer with the current R beat merged in, so the final beat can be
    // forwarded to resp_data_o on the same edge it is stored.
    always_comb begin
        rd_line_c = line_q;
        rd_line_c[rd_lsb_c +: AXI_DATA_WIDTH] = m_axi_rdata;
    end

    // Transaction FSM; every handshake output is a flop updated with the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            addr_q        <= '0;
            line_q        <= '0;
            req_ready_o   <= 1'b0;
            resp_valid_o  <= 1'b0;
            resp_data_o   <= '0;
            resp_err_o    <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wlast   <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        addr_q      <= aligned_addr_c;
                        line_q      <= req_data_i;
                        beat_q      <= '0;
                        resp_err_o  <= 1'b0;
                        resp_data_o <= '0;
                        if (req_we_i) begin
                            m_axi_awvalid <= 1'b1;
                            state_q       <= WR_ADDR;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state_q       <= RD_ADDR;
                        end
                    end
                end

                RD_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state_q       <= RD_DATA;
                    end
                end

                // Termination follows the beat count; rlast is only checked.
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        line_q <= rd_line_c;
                        if (m_axi_rresp != 2'b00) begin
                            resp_err_o <= 1'b1;
                        end
                        if (m_axi_rlast != (beat_q == LAST_BEAT)) begin
                            resp_err_o <= 1'b1;
                        end
                        if (beat_q == LAST_BEAT) begin
                            m_axi_rready <= 1'b0;
                            resp_valid_o <= 1'b1;
                            resp_data_o  <= rd_line_c;
                            beat_q       <= '0;
                            state_q      <= RESP;
                        end else begin
                            beat_q <= beat_next_c;
                        end
                    end
                end

                // W is only launched once AW has been taken.
                WR_ADDR: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b1;
                        m_axi_wdata   <= line_q[AXI_DATA_WIDTH-1:0];
                        m_axi_wlast   <= (LAST_BEAT == '0);
                        state_q       <= WR_DATA;
                    end
                end

                WR_DATA: begin
                    if (m_axi_wready) begin
                        if (m_axi_wlast) begin
                            m_axi_wvalid <= 1'b0;
                            m_axi_wlast  <= 1'b0;
                            m_axi_bready <= 1'b1;
                            beat_q       <= '0;
                            state_q      <= WR_RESP;
                        end else begin
                            beat_q      <= beat_next_c;
                            m_axi_wdata <= line_q[wr_lsb_c +: AXI_DATA_WIDTH];
                            m_axi_wlast <= (beat_next_c == LAST_BEAT);
                        end
                    end
                end

                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00) begin
                            resp_err_o <= 1'b1;
                        end
                        resp_valid_o <= 1'b1;
                        state_q      <= RESP;
                    end
                end

                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        resp_data_o  <= '0;
                        req_ready_o  <= 1'b1;
                        beat_q       <= '0;
                        state_q      <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_axi_line_bridge.sv
// Directed bench for dcache_axi_line_bridge: the bench plays the D$ and an
// AXI slave, drives inputs #1 after each rising edge and checks outputs there.
module tb_dcache_axi_line_bridge;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;

    logic         req_valid = 1'b0;
    logic         req_ready_o;
    logic         req_we = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [511:0] req_data = '0;
    logic         resp_valid_o;
    logic         resp_ready = 1'b0;
    logic [511:0] resp_data_o;
    logic         resp_err_o;

    logic         m_axi_arvalid;
    logic         m_axi_arready = 1'b0;
    logic [31:0]  m_axi_araddr;
    logic [3:0]   m_axi_arid;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_rvalid = 1'b0;
    logic         m_axi_rready;
    logic [31:0]  m_axi_rdata = '0;
    logic [1:0]   m_axi_rresp = '0;
    logic         m_axi_rlast = 1'b0;
    logic         m_axi_awvalid;
    logic         m_axi_awready = 1'b0;
    logic [31:0]  m_axi_awaddr;
    logic [3:0]   m_axi_awid;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_wvalid;
    logic         m_axi_wready = 1'b0;
    logic [31:0]  m_axi_wdata;
    logic [3:0]   m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_bvalid = 1'b0;
    logic         m_axi_bready;
    logic [1:0]   m_axi_bresp = '0;

    int n_checks = 0;
    int n_errors = 0;

    dcache_axi_line_bridge dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we),
        .req_addr_i    (req_addr),
        .req_data_i    (req_data),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready),
        .resp_data_o   (resp_data_o),
        .resp_err_o    (resp_err_o),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arid    (m_axi_arid),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awid    (m_axi_awid),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_bresp   (m_axi_bresp)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Line of 16 words base+0 .. base+15, word 0 in the low bits.
    function automatic logic [511:0] ramp(input logic [31:0] base);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = base + 32'(k);
        return r;
    endfunction

    task automatic issue_req(input logic we, input logic [31:0] addr, input logic [511:0] data);
        int guard;
        req_we    = we;
        req_addr  = addr;
        req_data  = data;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready_o && guard < 20) begin
            tick();
            guard++;
        end
        check("req_ready", req_ready_o, 1);
        tick();
        req_valid = 1'b0;
        req_data  = '0;
    endtask

    task automatic finish_resp(input int resp_wait, inout int lat,
                               output logic [511:0] data, output logic err);
        int guard;
        logic [511:0] d0;
        bit stable;
        bit ready_low;
        guard = 0;
        while (!resp_valid_o && guard < 20) begin
            tick();
            lat++;
            guard++;
        end
        check("resp_valid", resp_valid_o, 1);
        d0 = resp_data_o;
        stable = 1'b1;
        ready_low = !req_ready_o;
        for (int i = 0; i < resp_wait; i++) begin
            tick();
            lat++;
            if (!resp_valid_o || resp_data_o !== d0) stable = 1'b0;
            if (req_ready_o) ready_low = 1'b0;
        end
        if (resp_wait > 0) begin
            check("resp_stable", stable, 1);
            check("req_ready_low_in_resp", ready_low, 1);
        end
        data = resp_data_o;
        err  = resp_err_o;
        resp_ready = 1'b1;
        tick();
        lat++;
        resp_ready = 1'b0;
    endtask

    // Refill with a zero-wait slave returning base+k; optional bad rresp beat,
    // extra rlast beat, response back-pressure, or a reset before a beat.
    task automatic run_read(input logic [31:0] addr, input logic [31:0] base,
                            input int err_beat, input int last_beat, input int resp_wait,
                            input int rst_beat, output logic [511:0] data,
                            output logic err, output int lat);
        int guard;
        data = '0;
        err  = 1'b0;
        lat  = 0;
        issue_req(1'b0, addr, {16{32'hDEAD_BEEF}});
        check("arvalid", m_axi_arvalid, 1);
        check("araddr", m_axi_araddr, addr & 32'hFFFF_FFC0);
        check("ar_fields", {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst},
              {4'd0, 8'd15, 3'd2, 2'd1});
        m_axi_arready = 1'b1;
        tick();
        lat++;
        m_axi_arready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            guard = 0;
            while (!m_axi_rready && guard < 20) begin
                tick();
                lat++;
                guard++;
            end
            if (k == rst_beat) begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
                rst_ni = 1'b0;
                #1;
                check("reset_ctrl_outputs",
                      {req_ready_o, resp_valid_o, resp_err_o, m_axi_arvalid, m_axi_rready,
                       m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready}, 9'd0);
                check("reset_resp_data", resp_data_o, 512'd0);
                return;
            end
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = base + 32'(k);
            m_axi_rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast  = (k == 15) || (k == last_beat);
            tick();
            lat++;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        finish_resp(resp_wait, lat, data, err);
    endtask

    // Writeback with AW held off aw_delay cycles and optional random W stalls.
    task automatic run_write(input logic [31:0] addr, input logic [511:0] line,
                             input int aw_delay, input bit stalls, input logic [1:0] bresp,
                             output logic [511:0] data, output logic err, output int lat);
        int guard;
        int k;
        int bad_data;
        int bad_last;
        bit early_w;
        lat = 0;
        issue_req(1'b1, addr, line);
        check("awvalid", m_axi_awvalid, 1);
        check("awaddr", m_axi_awaddr, addr & 32'hFFFF_FFC0);
        check("aw_fields", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst},
              {4'd0, 8'd15, 3'd2, 2'd1});
        early_w = 1'b0;
        for (int d = 0; d < aw_delay; d++) begin
            if (m_axi_wvalid) early_w = 1'b1;
            tick();
            lat++;
        end
        if (m_axi_wvalid) early_w = 1'b1;
        m_axi_awready = 1'b1;
        tick();
        lat++;
        m_axi_awready = 1'b0;
        check("no_w_before_aw", early_w, 0);
        k = 0;
        guard = 0;
        bad_data = 0;
        bad_last = 0;
        while (k < 16 && guard < 200) begin
            m_axi_wready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (m_axi_wvalid && m_axi_wready) begin
                if (m_axi_wdata !== line[k*32 +: 32]) bad_data++;
                if (m_axi_wstrb !== 4'hF) bad_data++;
                if (m_axi_wlast !== (k == 15)) bad_last++;
                k++;
            end
            tick();
            lat++;
            guard++;
        end
        m_axi_wready = 1'b0;
        check("w_beat_count", k, 16);
        check("w_beat_data", bad_data, 0);
        check("w_last_pos", bad_last, 0);
        guard = 0;
        while (!m_axi_bready && guard < 20) begin
            tick();
            lat++;
            guard++;
        end
        check("bready", m_axi_bready, 1);
        check("no_resp_before_b", resp_valid_o, 0);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = bresp;
        tick();
        lat++;
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        finish_resp(0, lat, data, err);
    endtask

    logic [511:0] line_a5;
    logic [511:0] rdata;
    logic         rerr;
    int           lat;

    initial begin
        for (int k = 0; k < 16; k++) line_a5[k*32 +: 32] = 32'hA5A5_0000 + 32'(k);

        // Reset state
        #1;
        check("rst_ctrl_outputs",
              {req_ready_o, resp_valid_o, resp_err_o, m_axi_arvalid, m_axi_rready,
               m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready}, 9'd0);
        check("rst_resp_data", resp_data_o, 512'd0);
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (2) tick();
        check("idle_req_ready", req_ready_o, 1);

        // Plain refill, zero-wait slave
        run_read(32'h0000_1234, 32'h0000_1000, -1, -1, 0, -1, rdata, rerr, lat);
        check("rd_word0", rdata[31:0], 32'h0000_1000);
        check("rd_word15", rdata[511:480], 32'h0000_100F);
        check("rd_line", rdata, ramp(32'h0000_1000));
        check("rd_err", rerr, 0);
        check("rd_latency", lat, 18);

        // Writeback with AW delay and W stalls
        run_write(32'h8000_0040, line_a5, 3, 1'b1, 2'b00, rdata, rerr, lat);
        check("wr_resp_data", rdata, 512'd0);
        check("wr_err", rerr, 0);

        // SLVERR on beat 5
        run_read(32'h0000_2040, 32'h0000_2000, 5, -1, 0, -1, rdata, rerr, lat);
        check("rresp_err", rerr, 1);
        check("rresp_line", rdata, ramp(32'h0000_2000));

        // Early rlast on beat 7
        run_read(32'h0000_3080, 32'h0000_3000, -1, 7, 0, -1, rdata, rerr, lat);
        check("rlast_err", rerr, 1);
        check("rlast_line", rdata, ramp(32'h0000_3000));
        check("rlast_latency", lat, 18);

        // Response back-pressure, then back-to-back writeback with DECERR
        run_read(32'h0000_40C0, 32'h0000_4000, -1, -1, 10, -1, rdata, rerr, lat);
        check("bp_line", rdata, ramp(32'h0000_4000));
        check("bp_latency", lat, 28);
        check("b2b_ready", req_ready_o, 1);
        run_write(32'h0000_5000, ramp(32'h7700_0000), 0, 1'b0, 2'b11, rdata, rerr, lat);
        check("b2b_wr_latency", lat, 19);
        check("b2b_wr_err", rerr, 1);
        check("b2b_wr_data", rdata, 512'd0);

        // Reset during beat 8, then a fresh refill
        run_read(32'h0000_6000, 32'h0000_6000, -1, -1, 0, 8, rdata, rerr, lat);
        repeat (2) tick();
        rst_ni = 1'b1;
        repeat (2) tick();
        check("post_rst_ready", req_ready_o, 1);
        run_read(32'h0000_0FC4, 32'h0000_9000, -1, -1, 0, -1, rdata, rerr, lat);
        check("post_rst_line", rdata, ramp(32'h0000_9000));
        check("post_rst_err", rerr, 0);
        check("post_rst_latency", lat, 18);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
